// File: rtl/axi_read_arbiter.sv
// AXI3 read master shared by NUM_PORTS requesters: fixed priority, one outstanding burst,
// kseg0/kseg1 unmapping, a one-entry registered response buffer and per-port flush.
module axi_read_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PORT_W    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*4-1:0]      req_len,
    input  logic [NUM_PORTS-1:0]        req_flush,
    output logic [NUM_PORTS-1:0]        req_ready,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    input  logic [NUM_PORTS-1:0]        rsp_ready,
    output logic [DATA_W-1:0]           rsp_data,
    output logic                        rsp_last,
    output logic                        rsp_err,
    output logic                        busy,
    output logic [PORT_W-1:0]           active_port,
    output logic [3:0]                  arid,
    output logic [ADDR_W-1:0]           araddr,
    output logic [3:0]                  arlen,
    output logic [2:0]                  arsize,
    output logic [1:0]                  arburst,
    output logic [1:0]                  arlock,
    output logic [3:0]                  arcache,
    output logic [2:0]                  arprot,
    output logic                        arvalid,
    input  logic                        arready,
    input  logic [3:0]                  rid,
    input  logic [DATA_W-1:0]           rdata,
    input  logic [1:0]                  rresp,
    input  logic                        rlast,
    input  logic                        rvalid,
    output logic                        rready
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t                 r_state;
    logic                   r_arvalid;
    logic [NUM_PORTS-1:0]   r_req_ready;
    logic                   r_buf_v;
    logic [DATA_W-1:0]      r_rsp_data;
    logic                   r_rsp_last;
    logic                   r_rsp_err;
    logic                   r_discard;
    logic                   r_last_seen;
    logic [ADDR_W-1:0]      r_araddr;
    logic [3:0]             r_arlen;
    logic [3:0]             r_beat;
    logic [PORT_W-1:0]      r_port;

    logic                   w_any;
    logic [PORT_W-1:0]      w_sel;
    logic [NUM_PORTS-1:0]   w_grant;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [3:0]             w_sel_len;
    logic                   w_flush;
    logic                   w_rsp_rdy;
    logic                   w_rready;
    logic                   w_beat;
    logic                   w_drop;
    logic                   w_load;
    logic [3:0]             w_arid;
    logic                   w_unused;

    // kseg0 (100) and kseg1 (101) both alias physical memory from address zero
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] m;
        m = a;
        if (a[31:30] == 2'b10) m[31:29] = 3'b000;
        return m;
    endfunction

    function automatic logic beat_err(input logic [1:0] resp, input logic last,
                                      input logic [3:0] beat, input logic [3:0] len);
        return (resp != 2'b00) || (last && (beat != len)) || (!last && (beat == len));
    endfunction

    always_comb begin
        w_any   = |req_valid;
        w_sel   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_valid[i]) w_sel = PORT_W'(i);
        end
        w_grant        = '0;
        w_grant[w_sel] = w_any;
    end

    assign w_sel_addr = req_addr[int'(w_sel)*ADDR_W +: ADDR_W];
    assign w_sel_len  = req_len[int'(w_sel)*4 +: 4];
    assign w_flush    = req_flush[r_port];
    assign w_rsp_rdy  = rsp_ready[r_port];
    // Once rlast has been taken no further beat belongs to this burst
    assign w_rready   = (r_state == S_DATA) && !r_last_seen && (r_discard || !r_buf_v || w_rsp_rdy);
    assign w_beat     = rvalid && w_rready;
    assign w_drop     = r_discard || w_flush;
    assign w_load     = w_beat && !w_drop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_arvalid   <= 1'b0;
            r_req_ready <= '0;
            r_buf_v     <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_last  <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_discard   <= 1'b0;
            r_last_seen <= 1'b0;
            r_araddr    <= '0;
            r_arlen     <= '0;
            r_beat      <= '0;
            r_port      <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port      <= w_sel;
                        r_araddr    <= map_addr(w_sel_addr);
                        r_arlen     <= w_sel_len;
                        r_arvalid   <= 1'b1;
                        r_req_ready <= w_grant;
                        r_discard   <= 1'b0;
                        r_state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_flush) r_discard <= 1'b1;
                    if (arready) begin
                        r_arvalid   <= 1'b0;
                        r_beat      <= '0;
                        r_last_seen <= 1'b0;
                        r_state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat && rlast) r_last_seen <= 1'b1;
                    if (w_load) begin
                        r_rsp_data <= rdata;
                        r_rsp_last <= rlast;
                        r_rsp_err  <= beat_err(rresp, rlast, r_beat, r_arlen);
                        r_beat     <= r_beat + 4'd1;
                    end
                    if (w_flush) r_discard <= 1'b1;
                    if (w_load) r_buf_v <= 1'b1;
                    else if (w_drop || w_rsp_rdy) r_buf_v <= 1'b0;
                    if (r_last_seen && (w_drop || !r_buf_v || w_rsp_rdy)) begin
                        r_state   <= S_IDLE;
                        r_buf_v   <= 1'b0;
                        r_discard <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_arid         = '0;
        w_arid[PORT_W-1:0] = r_port;
        rsp_valid      = '0;
        rsp_valid[r_port] = r_buf_v && !r_discard;
    end

    assign w_unused    = ^rid;
    assign req_ready   = r_req_ready;
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign rsp_err     = r_rsp_err;
    assign busy        = (r_state != S_IDLE);
    assign active_port = r_port;
    assign arid        = w_arid;
    assign araddr      = r_araddr;
    assign arlen       = r_arlen;
    assign arsize      = 3'($clog2(DATA_W / 8));
    assign arburst     = 2'b01;
    assign arlock      = 2'b00;
    assign arcache     = 4'b0000;
    assign arprot      = 3'b001;
    assign arvalid     = r_arvalid;
    assign rready      = w_rready;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: two ports, hand-computed expectations per scenario.
module tb_axi_read_arbiter;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [63:0] req_addr;
    logic [7:0]  req_len;
    logic [1:0]  req_flush;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        rsp_err;
    logic        busy;
    logic [0:0]  active_port;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;

    axi_read_arbiter #(.NUM_PORTS(2), .ADDR_W(32), .DATA_W(32), .PORT_W(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_flush(req_flush),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .busy(busy), .active_port(active_port),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_addr = '0; req_len = '0; req_flush = '0; rsp_ready = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
    endtask

    task automatic request(input int p, input logic [31:0] a, input logic [3:0] l);
        req_valid = '0;
        req_valid[p] = 1'b1;
        req_addr[p*32 +: 32] = a;
        req_len[p*4 +: 4] = l;
        tick();
        req_valid = '0;
    endtask

    task automatic addr_hs();
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        tick(); tick();
        n_tests++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_req_ready: got %b want 00", req_ready); end
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", rsp_valid); end
        n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready: got %b want 0", rready); end
        n_tests++; if (araddr !== 32'h0) begin n_fail++; $display("FAIL rst_araddr: got %h want 0", araddr); end
        n_tests++; if ({arsize, arburst, arlock, arcache, arprot} !== {3'd2, 2'b01, 2'b00, 4'h0, 3'b001})
            begin n_fail++; $display("FAIL rst_const_fields: got %h %h %h %h %h want 2 1 0 0 1", arsize, arburst, arlock, arcache, arprot); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        request(1, 32'hBFC0_0000, 4'd0);
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL single_req_ready: got %b want 10", req_ready); end
        n_tests++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL single_arvalid: got %b want 1", arvalid); end
        n_tests++; if (araddr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL single_araddr: got %h want 1fc00000", araddr); end
        n_tests++; if ({arid, arlen} !== {4'd1, 4'd0}) begin n_fail++; $display("FAIL single_arid_arlen: got %h %h want 1 0", arid, arlen); end
        tick();
        n_tests++; if ({arvalid, req_ready} !== 3'b100) begin n_fail++; $display("FAIL single_hold: got %b want 100", {arvalid, req_ready}); end
        tick();
        addr_hs();
        n_tests++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL single_ar_done: got %b want 01", {arvalid, rready}); end
        rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        n_tests++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 10", rsp_valid); end
        n_tests++; if ({rsp_data, rsp_last, rsp_err} !== {32'h1234_5678, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL single_rsp: got %h %b %b want 12345678 1 0", rsp_data, rsp_last, rsp_err); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold: got %b want 1", busy); end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
        n_tests++; if ({busy, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL single_done: got %b want 000", {busy, rsp_valid}); end
    endtask

    task automatic test_priority();
        req_valid = 2'b11;
        req_addr = {32'h0000_2000, 32'h0000_1000};
        req_len = 8'h00;
        tick();
        req_valid = 2'b10;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL prio_first: got %b want 01", req_ready); end
        n_tests++; if ({araddr, active_port} !== {32'h0000_1000, 1'b0}) begin n_fail++; $display("FAIL prio_first_addr: got %h %b want 00001000 0", araddr, active_port); end
        addr_hs();
        rvalid = 1'b1; rdata = 32'hAAAA_0000; rlast = 1'b1; rsp_ready = 2'b11;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL prio_rsp0: got %b want 01", rsp_valid); end
        tick();
        n_tests++; if ({busy, req_ready} !== 3'b000) begin n_fail++; $display("FAIL prio_gap: got %b want 000", {busy, req_ready}); end
        tick();
        req_valid = 2'b00;
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL prio_second: got %b want 10", req_ready); end
        n_tests++; if ({araddr, arid} !== {32'h0000_2000, 4'd1}) begin n_fail++; $display("FAIL prio_second_addr: got %h %h want 00002000 1", araddr, arid); end
        addr_hs();
        rvalid = 1'b1; rdata = 32'hBBBB_0000; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        n_tests++; if ({rsp_valid, rsp_data} !== {2'b10, 32'hBBBB_0000}) begin n_fail++; $display("FAIL prio_rsp1: got %b %h want 10 bbbb0000", rsp_valid, rsp_data); end
        tick();
        rsp_ready = 2'b00;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_done: got %b want 0", busy); end
    endtask

    task automatic test_burst_backpressure();
        int sent, got, k;
        logic [3:0] pat;
        sent = 0; got = 0; k = 0; pat = 4'b1101;
        request(0, 32'h8000_0100, 4'd3);
        n_tests++; if ({araddr, arlen, arid} !== {32'h0000_0100, 4'd3, 4'd0}) begin n_fail++; $display("FAIL burst_ar: got %h %h %h want 00000100 3 0", araddr, arlen, arid); end
        addr_hs();
        for (int cyc = 0; cyc < 40 && !(got == 4 && busy == 1'b0); cyc++) begin
            rvalid = (sent < 4);
            rdata = 32'hD000_0000 + sent;
            rlast = (sent == 3);
            rresp = 2'b00;
            rsp_ready[0] = (rsp_valid[0] && k < 4) ? pat[k] : 1'b1;
            #1;
            if (rsp_valid[1] !== 1'b0) begin n_tests++; n_fail++; $display("FAIL burst_wrong_port: got %b want 0", rsp_valid[1]); end
            if (rsp_valid[0] && rsp_ready[0]) begin
                n_tests++; if ({rsp_data, rsp_last, rsp_err} !== {32'hD000_0000 + got, (got == 3), 1'b0})
                    begin n_fail++; $display("FAIL burst_beat%0d: got %h %b %b want %h %b 0", got, rsp_data, rsp_last, rsp_err, 32'hD000_0000 + got, (got == 3)); end
                got++;
            end
            if (rsp_valid[0]) k++;
            if (rvalid && rready) sent++;
            tick();
        end
        rvalid = 1'b0; rlast = 1'b0; rsp_ready = 2'b00;
        n_tests++; if (got != 4 || busy !== 1'b0) begin n_fail++; $display("FAIL burst_complete: got beats=%0d busy=%b want 4 0", got, busy); end
    endtask

    task automatic test_flush();
        request(1, 32'h0000_3000, 4'd3);
        addr_hs();
        rsp_ready = 2'b00; rvalid = 1'b1; rdata = 32'hB000_0000; rlast = 1'b0;
        tick();
        rvalid = 1'b0;
        n_tests++; if ({rsp_valid, rsp_data} !== {2'b10, 32'hB000_0000}) begin n_fail++; $display("FAIL flush_pre: got %b %h want 10 b0000000", rsp_valid, rsp_data); end
        req_flush = 2'b01;
        tick();
        req_flush = 2'b00;
        n_tests++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL flush_other_port: got %b want 10", rsp_valid); end
        req_flush = 2'b10;
        tick();
        req_flush = 2'b00;
        n_tests++; if ({rsp_valid, rready} !== 3'b001) begin n_fail++; $display("FAIL flush_drop: got %b want 001", {rsp_valid, rready}); end
        for (int b = 1; b < 4; b++) begin
            rvalid = 1'b1; rdata = 32'hB000_0000 + b; rlast = (b == 3);
            #1;
            n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL flush_rready%0d: got %b want 1", b, rready); end
            tick();
            n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL flush_swallow%0d: got %b want 00", b, rsp_valid); end
        end
        rvalid = 1'b0; rlast = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got %b want 0", busy); end
        request(0, 32'hA000_0040, 4'd0);
        n_tests++; if ({req_ready, araddr} !== {2'b01, 32'h0000_0040}) begin n_fail++; $display("FAIL flush_next_req: got %b %h want 01 00000040", req_ready, araddr); end
        addr_hs();
        rvalid = 1'b1; rdata = 32'h7777_7777; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        n_tests++; if ({rsp_valid, rsp_data, rsp_last, rsp_err} !== {2'b01, 32'h7777_7777, 1'b1, 1'b0})
            begin n_fail++; $display("FAIL flush_next_rsp: got %b %h %b %b want 01 77777777 1 0", rsp_valid, rsp_data, rsp_last, rsp_err); end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_next_done: got %b want 0", busy); end
    endtask

    task automatic test_errors();
        request(0, 32'h4000_0000, 4'd3);
        n_tests++; if (araddr !== 32'h4000_0000) begin n_fail++; $display("FAIL err_passthrough: got %h want 40000000", araddr); end
        addr_hs();
        rsp_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rdata = 32'hC000_0000 + k; rlast = (k == 3); rresp = (k == 1) ? 2'b10 : 2'b00;
            tick();
            n_tests++; if ({rsp_valid, rsp_err, rsp_last} !== {2'b01, (k == 1), (k == 3)})
                begin n_fail++; $display("FAIL err_rresp_beat%0d: got %b %b %b want 01 %b %b", k, rsp_valid, rsp_err, rsp_last, (k == 1), (k == 3)); end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_rresp_done: got %b want 0", busy); end
        request(0, 32'h4000_0100, 4'd3);
        addr_hs();
        rvalid = 1'b1; rdata = 32'hE000_0000; rlast = 1'b1;
        tick();
        rvalid = 1'b0; rlast = 1'b0;
        n_tests++; if ({rsp_valid, rsp_err, rsp_last} !== {2'b01, 1'b1, 1'b1}) begin n_fail++; $display("FAIL err_early_last: got %b %b %b want 01 1 1", rsp_valid, rsp_err, rsp_last); end
        tick();
        rsp_ready = 2'b00;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_early_end: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        request(1, 32'h9000_0000, 4'd3);
        addr_hs();
        rsp_ready = 2'b00; rvalid = 1'b1; rdata = 32'h5555_5555; rlast = 1'b1; rresp = 2'b11;
        tick();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        n_tests++; if ({rsp_valid, rsp_err} !== {2'b10, 1'b1}) begin n_fail++; $display("FAIL rmid_pre: got %b %b want 10 1", rsp_valid, rsp_err); end
        reset = 1'b0;
        tick();
        n_tests++; if ({arvalid, rready, req_ready, rsp_valid, rsp_last, rsp_err, busy} !== 9'b0)
            begin n_fail++; $display("FAIL rmid_ctrl: got %b want 000000000", {arvalid, rready, req_ready, rsp_valid, rsp_last, rsp_err, busy}); end
        n_tests++; if ({araddr, arlen, arid, rsp_data, active_port} !== 73'b0)
            begin n_fail++; $display("FAIL rmid_data: got %h %h %h %h %b want zeros", araddr, arlen, arid, rsp_data, active_port); end
        reset = 1'b1;
        tick();
        n_tests++; if ({busy, arvalid} !== 2'b00) begin n_fail++; $display("FAIL rmid_idle: got %b want 00", {busy, arvalid}); end
        request(0, 32'h0000_0400, 4'd0);
        n_tests++; if ({req_ready, arvalid, araddr} !== {2'b01, 1'b1, 32'h0000_0400}) begin n_fail++; $display("FAIL rmid_restart: got %b %b %h want 01 1 00000400", req_ready, arvalid, araddr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_burst_backpressure();
        test_flush();
        test_errors();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
